// File: rtl/serial_add_seq_if.sv
// Handshake and full-adder cell bundle for the bit-serial add sequencer.
// The slave side is the sequencer; the master side is the environment, which owns the adder cell.
interface serial_add_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, fa_sum, fa_cout, out_ready,
    output in_ready, fa_a, fa_b, fa_cin, out_valid, out_sum, out_cout, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, fa_sum, fa_cout, out_ready,
    input  in_ready, fa_a, fa_b, fa_cin, out_valid, out_sum, out_cout, busy
  );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial add sequencer: feeds one external full-adder cell LSB-first,
// holds the carry in a flop and collects the sum bits into a shift register.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic            CK,
  input  logic            RST,
  serial_add_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] sum_sr_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] res_sum_r;
  logic             res_cout_r;

  logic             run_s;
  logic             last_bit_s;
  logic [WIDTH:0]   sum_ext_s;
  logic [WIDTH-1:0] sum_nxt_s;

  assign run_s      = (state_r == ST_RUN);
  assign last_bit_s = (cnt_r == CW'(WIDTH - 1));

  // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
  assign sum_ext_s  = {bus.fa_sum, sum_sr_r};
  assign sum_nxt_s  = sum_ext_s[WIDTH:1];

  // Next-state decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_bit_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, operand shifters, carry flop, bit counter and result holding registers.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      a_sr_r     <= {WIDTH{1'b0}};
      b_sr_r     <= {WIDTH{1'b0}};
      sum_sr_r   <= {WIDTH{1'b0}};
      carry_r    <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      res_sum_r  <= {WIDTH{1'b0}};
      res_cout_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_sr_r  <= bus.in_a;
            b_sr_r  <= bus.in_b;
            carry_r <= bus.in_cin;
            cnt_r   <= {CW{1'b0}};
          end
        end
        ST_RUN: begin
          sum_sr_r <= sum_nxt_s;
          carry_r  <= bus.fa_cout;
          a_sr_r   <= a_sr_r >> 1;
          b_sr_r   <= b_sr_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
          // Result registers only change when a complete result exists,
          // so out_sum/out_cout keep the previous answer during RUN.
          if (last_bit_s) begin
            res_sum_r  <= sum_nxt_s;
            res_cout_r <= bus.fa_cout;
          end
        end
        ST_DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == ST_IDLE);
  assign bus.out_valid = (state_r == ST_DONE);
  assign bus.busy      = run_s | (state_r == ST_DONE);
  assign bus.fa_a      = run_s & a_sr_r[0];
  assign bus.fa_b      = run_s & b_sr_r[0];
  assign bus.fa_cin    = run_s & carry_r;
  assign bus.out_sum   = res_sum_r;
  assign bus.out_cout  = res_cout_r;

endmodule
